// File: rtl/blocky_pkg.sv
// Shared encodings for the Blocky keyboard front end: game status, PS/2 parser
// states and the scan-code bytes the decoder reacts to.
package blocky_pkg;

    typedef enum logic [3:0] {
        ST_NONE      = 4'b0000,
        ST_LOAD      = 4'b1000,
        ST_ACTIVATE  = 4'b0100,
        ST_PAUSE     = 4'b0010,
        ST_TERMINATE = 4'b0001
    } status_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_BRK,
        P_EXT,
        P_EXT_BRK
    } parse_t;

    localparam logic [7:0] SC_BREAK     = 8'hF0;
    localparam logic [7:0] SC_EXT       = 8'hE0;
    localparam logic [7:0] SC_PAUSE_SEQ = 8'hE1;
    localparam logic [7:0] SC_SPACE     = 8'h29;
    localparam logic [7:0] SC_P         = 8'h4D;
    localparam logic [7:0] SC_ESC       = 8'h76;
    localparam logic [7:0] SC_UP        = 8'h1D;
    localparam logic [7:0] SC_DOWN      = 8'h1B;
    localparam logic [7:0] SC_LEFT      = 8'h1C;
    localparam logic [7:0] SC_RIGHT     = 8'h23;
    localparam logic [7:0] SC_EXT_UP    = 8'h75;
    localparam logic [7:0] SC_EXT_DOWN  = 8'h72;
    localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
    localparam logic [7:0] SC_EXT_RIGHT = 8'h74;

    // Direction bit {up, down, left, right} for a key, or zero if it is not a direction key.
    function automatic logic [3:0] dir_mask(input logic ext, input logic [7:0] sc);
        logic [3:0] m;
        m = 4'b0000;
        if (ext) begin
            case (sc)
                SC_EXT_UP:    m = 4'b1000;
                SC_EXT_DOWN:  m = 4'b0100;
                SC_EXT_LEFT:  m = 4'b0010;
                SC_EXT_RIGHT: m = 4'b0001;
                default:      m = 4'b0000;
            endcase
        end else begin
            case (sc)
                SC_UP:    m = 4'b1000;
                SC_DOWN:  m = 4'b0100;
                SC_LEFT:  m = 4'b0010;
                SC_RIGHT: m = 4'b0001;
                default:  m = 4'b0000;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/repeat_timer.sv
// Auto-repeat timebase: after start, step fires DELAY_CYCLES later and then
// every REPEAT_CYCLES until stop (or a new start).
module repeat_timer #(
    parameter int DELAY_CYCLES  = 12500000,
    parameter int REPEAT_CYCLES = 2500000,
    parameter int CNT_W         = 24
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic stop,
    output logic step
);

    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'((DELAY_CYCLES  > 0) ? DELAY_CYCLES  - 1 : 0);
    localparam logic [CNT_W-1:0] RPT_LOAD = CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    logic             active;
    logic [CNT_W-1:0] cnt;

    // A same-cycle start or stop wins over an expiring count.
    assign step = active && (cnt == '0) && !start && !stop;

    always_ff @(posedge clk) begin
        if (clr) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= DLY_LOAD;
        end else if (stop) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (active) begin
            cnt <= (cnt == '0) ? RPT_LOAD : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/key_cmd_decoder.sv
// PS/2 scan-code decoder for Blocky: tracks held direction keys, drives the
// game status FSM and generates direction step pulses with auto-repeat.
module key_cmd_decoder
    import blocky_pkg::*;
#(
    parameter int DELAY_CYCLES  = 12500000,
    parameter int REPEAT_CYCLES = 2500000,
    parameter int CNT_W         = 24
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       code_valid,
    input  logic [7:0] code,
    input  logic       game_over,
    output logic [3:0] status,
    output logic [3:0] direction,
    output logic [3:0] dir_step
);

    parse_t     p_state, p_state_nxt;
    status_t    status_q, status_nxt;
    logic       ev_make, ev_break, ev_ext;
    logic [3:0] key_bit;
    logic       space_make, space_break, p_make, esc_make;
    logic [3:0] held_q, held_nxt;
    logic [3:0] rpt_key_q, rpt_key_nxt;
    logic [3:0] direction_q, dir_step_q, dir_step_nxt;
    logic       in_act, fresh, rpt_start, rpt_stop, rpt_step;

    always_comb begin
        p_state_nxt = p_state;
        ev_make     = 1'b0;
        ev_break    = 1'b0;
        ev_ext      = 1'b0;
        if (code_valid) begin
            case (p_state)
                P_IDLE: begin
                    if (code == SC_BREAK)          p_state_nxt = P_BRK;
                    else if (code == SC_EXT)       p_state_nxt = P_EXT;
                    else if (code != SC_PAUSE_SEQ) ev_make     = 1'b1;
                end
                P_EXT: begin
                    if (code == SC_BREAK) begin
                        p_state_nxt = P_EXT_BRK;
                    end else begin
                        ev_make     = 1'b1;
                        ev_ext      = 1'b1;
                        p_state_nxt = P_IDLE;
                    end
                end
                P_BRK: begin
                    ev_break    = 1'b1;
                    p_state_nxt = P_IDLE;
                end
                P_EXT_BRK: begin
                    ev_break    = 1'b1;
                    ev_ext      = 1'b1;
                    p_state_nxt = P_IDLE;
                end
                default: p_state_nxt = P_IDLE;
            endcase
        end
    end

    assign key_bit     = dir_mask(ev_ext, code);
    assign space_make  = ev_make  && !ev_ext && (code == SC_SPACE);
    assign space_break = ev_break && !ev_ext && (code == SC_SPACE);
    assign p_make      = ev_make  && !ev_ext && (code == SC_P);
    assign esc_make    = ev_make  && !ev_ext && (code == SC_ESC);

    // A crash beats any key event; Esc beats the per-state transitions.
    always_comb begin
        status_nxt = status_q;
        if (game_over && (status_q == ST_ACTIVATE || status_q == ST_PAUSE)) begin
            status_nxt = ST_TERMINATE;
        end else if (esc_make && status_q != ST_NONE) begin
            status_nxt = ST_NONE;
        end else begin
            case (status_q)
                ST_NONE:      if (space_make)  status_nxt = ST_LOAD;
                ST_LOAD:      if (space_break) status_nxt = ST_ACTIVATE;
                ST_ACTIVATE:  if (p_make)      status_nxt = ST_PAUSE;
                ST_PAUSE:     if (p_make)      status_nxt = ST_ACTIVATE;
                ST_TERMINATE: if (space_make)  status_nxt = ST_LOAD;
                default:                       status_nxt = ST_NONE;
            endcase
        end
    end

    always_comb begin
        held_nxt = held_q;
        if (ev_make)  held_nxt = held_nxt | key_bit;
        if (ev_break) held_nxt = held_nxt & ~key_bit;
    end

    // Repeat only runs while activate holds across the cycle; anything else disarms it.
    assign in_act = (status_q == ST_ACTIVATE) && (status_nxt == ST_ACTIVATE);
    assign fresh  = ev_make && (key_bit != 4'b0000) && ((held_q & key_bit) == 4'b0000);

    always_comb begin
        rpt_key_nxt  = rpt_key_q;
        rpt_start    = 1'b0;
        rpt_stop     = 1'b0;
        dir_step_nxt = 4'b0000;
        if (!in_act) begin
            rpt_key_nxt = 4'b0000;
            rpt_stop    = 1'b1;
        end else if (fresh) begin
            rpt_key_nxt  = key_bit;
            rpt_start    = 1'b1;
            dir_step_nxt = key_bit;
        end else if (ev_break && ((key_bit & rpt_key_q) != 4'b0000)) begin
            rpt_key_nxt = 4'b0000;
            rpt_stop    = 1'b1;
        end else if (rpt_step) begin
            dir_step_nxt = rpt_key_q;
        end
    end

    repeat_timer #(
        .DELAY_CYCLES (DELAY_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .CNT_W        (CNT_W)
    ) u_repeat_timer (
        .clk  (clk),
        .clr  (clr),
        .start(rpt_start),
        .stop (rpt_stop),
        .step (rpt_step)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            p_state     <= P_IDLE;
            status_q    <= ST_NONE;
            held_q      <= 4'b0000;
            rpt_key_q   <= 4'b0000;
            direction_q <= 4'b0000;
            dir_step_q  <= 4'b0000;
        end else begin
            p_state     <= p_state_nxt;
            status_q    <= status_nxt;
            held_q      <= held_nxt;
            rpt_key_q   <= rpt_key_nxt;
            direction_q <= (status_nxt == ST_ACTIVATE) ? held_nxt : 4'b0000;
            dir_step_q  <= dir_step_nxt;
        end
    end

    assign status    = status_q;
    assign direction = direction_q;
    assign dir_step  = dir_step_q;

endmodule

// File: tb/tb_key_cmd_decoder.sv
// Bench for key_cmd_decoder: directed scenarios with literal expectations plus
// randomized scan-code traffic checked every cycle against a behavioural model.
module tb_key_cmd_decoder;

    localparam int DLY = 8;
    localparam int RPT = 4;

    localparam logic [3:0] S_NONE = 4'b0000;
    localparam logic [3:0] S_LOAD = 4'b1000;
    localparam logic [3:0] S_ACT  = 4'b0100;
    localparam logic [3:0] S_PAU  = 4'b0010;
    localparam logic [3:0] S_TERM = 4'b0001;

    logic       clk = 1'b0;
    logic       clr;
    logic       cv;
    logic [7:0] code;
    logic       go;
    logic [3:0] status, direction, dir_step;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] tbl [16] = '{8'hF0, 8'hF0, 8'hE0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75,
                             8'h72, 8'h6B, 8'h74, 8'h29, 8'h29, 8'h4D, 8'h76, 8'hE1};

    key_cmd_decoder #(
        .DELAY_CYCLES (DLY),
        .REPEAT_CYCLES(RPT),
        .CNT_W        (24)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .code_valid(cv),
        .code      (code),
        .game_over (go),
        .status    (status),
        .direction (direction),
        .dir_step  (dir_step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Direction index 0..3 = up, down, left, right; -1 when not a direction key.
    function automatic int key_idx(input bit ext, input logic [7:0] c);
        if (!ext) begin
            case (c)
                8'h1D: return 0;
                8'h1B: return 1;
                8'h1C: return 2;
                8'h23: return 3;
                default: return -1;
            endcase
        end
        case (c)
            8'h75: return 0;
            8'h72: return 1;
            8'h6B: return 2;
            8'h74: return 3;
            default: return -1;
        endcase
    endfunction

    // Behavioural model: prefix flags, held-key set, repeat key with absolute due time.
    initial begin : model
        bit         m_valid, m_brk, m_ext, mk, bk, ex, fresh, stay;
        logic [3:0] m_status, m_held, m_dir, m_step, nst;
        int         m_rpt, m_next, cyc, idx;
        m_valid = 0; m_brk = 0; m_ext = 0; m_rpt = -1; m_next = 0; cyc = 0;
        m_status = 0; m_held = 0; m_dir = 0; m_step = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (clr) begin
                m_valid = 1; m_brk = 0; m_ext = 0; m_rpt = -1;
                m_status = S_NONE; m_held = 0; m_dir = 0; m_step = 0;
            end else begin
                mk = 0; bk = 0; ex = 0;
                if (cv) begin
                    if (m_brk) begin
                        bk = 1; ex = m_ext; m_brk = 0; m_ext = 0;
                    end else if (code == 8'hF0) begin
                        m_brk = 1;
                    end else if (code == 8'hE0 && !m_ext) begin
                        m_ext = 1;
                    end else begin
                        mk = 1; ex = m_ext; m_ext = 0;
                    end
                end
                idx = (mk || bk) ? key_idx(ex, code) : -1;
                nst = m_status;
                if (go && (m_status == S_ACT || m_status == S_PAU)) nst = S_TERM;
                else if (mk && !ex && code == 8'h76 && m_status != S_NONE) nst = S_NONE;
                else if (!ex) begin
                    if (mk && code == 8'h29 && (m_status == S_NONE || m_status == S_TERM)) nst = S_LOAD;
                    if (bk && code == 8'h29 && m_status == S_LOAD) nst = S_ACT;
                    if (mk && code == 8'h4D && m_status == S_ACT) nst = S_PAU;
                    if (mk && code == 8'h4D && m_status == S_PAU) nst = S_ACT;
                end
                stay  = (m_status == S_ACT) && (nst == S_ACT);
                fresh = mk && idx >= 0 && !m_held[3-idx];
                if (mk && idx >= 0) m_held[3-idx] = 1'b1;
                if (bk && idx >= 0) m_held[3-idx] = 1'b0;
                m_step = 4'b0000;
                if (!stay) m_rpt = -1;
                else if (fresh) begin
                    m_rpt = idx; m_step = 4'b1000 >> idx; m_next = cyc + DLY;
                end else if (bk && idx >= 0 && idx == m_rpt) m_rpt = -1;
                else if (m_rpt >= 0 && cyc == m_next) begin
                    m_step = 4'b1000 >> m_rpt; m_next = cyc + RPT;
                end
                m_status = nst;
                m_dir = (nst == S_ACT) ? m_held : 4'b0000;
            end
            #1;
            if (m_valid) begin
                chk("model_status", {28'h0, status}, {28'h0, m_status});
                chk("model_direction", {28'h0, direction}, {28'h0, m_dir});
                chk("model_dir_step", {28'h0, dir_step}, {28'h0, m_step});
            end
        end
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic send(input logic [7:0] b);
        cv = 1'b1; code = b;
        @(negedge clk);
        cv = 1'b0;
    endtask

    task automatic count_steps(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (dir_step != 4'b0000) c++;
        end
    endtask

    task automatic activate();
        send(8'h29); send(8'hF0); send(8'h29);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int pulses, c, c0, c1;
        clr = 1'b1; cv = 1'b0; code = 8'h00; go = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_status", {28'h0, status}, 32'h0);
        chk("reset_direction", {28'h0, direction}, 32'h0);
        chk("reset_dir_step", {28'h0, dir_step}, 32'h0);
        clr = 1'b0;

        send(8'h29);  chk("space_load", {28'h0, status}, 32'h8);
        send(8'hF0);  chk("load_hold", {28'h0, status}, 32'h8);
        send(8'h29);  chk("space_activate", {28'h0, status}, 32'h4);

        send(8'hE0); send(8'h75);
        chk("up_first_step", {28'h0, dir_step}, 32'h8);
        chk("up_direction", {28'h0, direction}, 32'h8);
        pulses = 0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (dir_step[3]) pulses |= (1 << k);
        end
        chk("up_repeat_times", pulses, 32'h0001_1100);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_break_direction", {28'h0, direction}, 32'h0);
        count_steps(20, c);
        chk("up_no_step_after_break", c, 0);

        send(8'h1C);
        chk("left_direction", {28'h0, direction}, 32'h2);
        chk("left_step", {28'h0, dir_step}, 32'h2);
        repeat (3) @(negedge clk);
        send(8'h23);
        chk("left_right_direction", {28'h0, direction}, 32'h3);
        chk("right_step", {28'h0, dir_step}, 32'h1);
        c0 = 0; c1 = 0;
        repeat (10) begin
            @(negedge clk);
            if (dir_step[0]) c0++;
            if (dir_step[1]) c1++;
        end
        chk("right_repeats", c0, 1);
        chk("left_no_repeat", c1, 0);
        send(8'hF0); send(8'h23);
        chk("right_break_direction", {28'h0, direction}, 32'h2);
        count_steps(20, c);
        chk("no_resume_after_break", c, 0);
        send(8'hF0); send(8'h1C);

        go = 1'b1; cv = 1'b1; code = 8'h4D;
        @(negedge clk);
        go = 1'b0; cv = 1'b0;
        chk("game_over_priority", {28'h0, status}, 32'h1);
        send(8'h29);  chk("terminate_to_load", {28'h0, status}, 32'h8);

        send(8'hE0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_status", {28'h0, status}, 32'h0);
        send(8'h75);
        chk("dropped_prefix_status", {28'h0, status}, 32'h0);
        chk("dropped_prefix_step", {28'h0, dir_step}, 32'h0);
        activate();
        chk("dropped_prefix_not_held", {28'h0, direction}, 32'h0);

        send(8'h1D);  chk("pause_setup_step", {28'h0, dir_step}, 32'h8);
        send(8'h4D);
        chk("pause_status", {28'h0, status}, 32'h2);
        chk("pause_direction", {28'h0, direction}, 32'h0);
        count_steps(15, c);
        chk("pause_no_steps", c, 0);
        send(8'h4D);
        chk("resume_status", {28'h0, status}, 32'h4);
        chk("resume_direction", {28'h0, direction}, 32'h8);
        chk("resume_no_step", {28'h0, dir_step}, 32'h0);
        count_steps(15, c);
        chk("resume_no_repeat", c, 0);
        send(8'hF0); send(8'h1D);
        send(8'h76);  chk("esc_none", {28'h0, status}, 32'h0);

        for (int i = 0; i < 4000; i++) begin
            clr  = ($urandom_range(0, 299) == 0);
            go   = ($urandom_range(0, 59) == 0);
            cv   = ($urandom_range(0, 3) == 0);
            code = ($urandom_range(0, 9) == 0) ? 8'($urandom) : tbl[$urandom_range(0, 15)];
            @(negedge clk);
        end
        clr = 1'b0; go = 1'b0; cv = 1'b0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/key_cmd_decoder.md
KEY_CMD_DECODER -- requirements
Module: key_cmd_decoder

Interface
REQ-001 Parameter DELAY_CYCLES, default 12500000, clk cycles from first press to first auto-repeat step (0.5 s at 25 MHz).
REQ-002 Parameter REPEAT_CYCLES, default 2500000, clk cycles between subsequent auto-repeat steps.
REQ-003 Parameter CNT_W, default 24, repeat counter width; SHALL hold max(DELAY_CYCLES, REPEAT_CYCLES).
REQ-004 clk  in  1  system clock (25 MHz domain of the PS/2 receiver); sole clock of the block.
REQ-005 clr  in  1  reset, synchronous, active-high.
REQ-006 code_valid  in  1  one-cycle strobe: new scan-code byte on code.
REQ-007 code  in  8  received PS/2 scan-code byte.
REQ-008 game_over  in  1  level from game logic: the car has crashed.
REQ-009 status  out  4  one-hot game status: load 1000, activate 0100, pause 0010, terminate 0001, none 0000.
REQ-010 direction  out  4  held-key mask {up, down, left, right}; active only in activate.
REQ-011 dir_step  out  4  one-cycle step pulses, same bit order, including auto-repeat.

Function
REQ-012 Parser FSM states: P_IDLE, P_BRK (after F0), P_EXT (after E0), P_EXT_BRK (after E0 F0); it SHALL advance only on code_valid.
REQ-013 P_IDLE: F0 -> P_BRK; E0 -> P_EXT; any other byte is a make of that code, then stay in P_IDLE.
REQ-014 P_EXT: F0 -> P_EXT_BRK; other byte is an extended make -> P_IDLE. P_BRK/P_EXT_BRK: any byte is a (extended) break -> P_IDLE.
REQ-015 E1 or any unmapped byte SHALL produce no action, and the parser SHALL return to P_IDLE after that byte.
REQ-016 Direction keys: up = 1D or E0 75; down = 1B or E0 72; left = 1C or E0 6B; right = 23 or E0 74.
REQ-017 Held mask SHALL set a bit on make and clear it on break, one cycle after the code_valid; repeated makes (typematic) of a held key SHALL not alter the mask.
REQ-018 Game FSM: none -Space(29) make-> load; load -Space break-> activate; activate -P(4D) make-> pause; pause -P make-> activate; any state except none -Esc(76) make-> none; terminate -Space make-> load.
REQ-019 game_over high in activate or pause SHALL force terminate on the next cycle; game_over has priority over a same-cycle key event.
REQ-020 direction SHALL equal the held mask while status is activate, else 4'b0000; the held mask SHALL keep tracking in all states.
REQ-021 Fresh make of a direction key in activate (bit was clear) SHALL pulse that dir_step bit one cycle after code_valid and make it the repeat key.
REQ-022 While the repeat key stays held, further dir_step pulses SHALL occur after DELAY_CYCLES, then every REPEAT_CYCLES.
REQ-023 Break of the repeat key, or leaving activate, SHALL stop repeating immediately; other held keys SHALL not resume repeating until re-pressed.
REQ-024 Only one dir_step bit SHALL be high in any cycle; a fresh make pulse overrides a same-cycle repeat pulse.
REQ-025 status and direction SHALL be registered; code_valid to output change latency is exactly one cycle.

Reset
REQ-026 While clr is high at a clk edge: status none, direction 0, dir_step 0, held mask 0, parser P_IDLE, repeat counter 0, repeat key none.
REQ-027 clr SHALL override all inputs in the same cycle; a byte arriving with clr high SHALL be discarded, and a prefix (F0/E0) pending at reset SHALL be dropped.

Structure
REQ-028 Status encodings, parser state encodings and all scan-code constants SHALL live in shared package blocky_pkg.
REQ-029 Repeat timing SHALL be a sub-module repeat_timer (start, stop, step out; DELAY_CYCLES/REPEAT_CYCLES/CNT_W parameters).

Verification (DELAY_CYCLES=8, REPEAT_CYCLES=4 in bench)
REQ-030 29, then F0 29 -> status 1000 after 29, 0100 one cycle after the second 29.
REQ-031 In activate: E0 75, hold 20 cycles, E0 F0 75 -> direction 1000 while held; dir_step[3] at +1, +9, +13, +17; nothing after break.
REQ-032 In activate: 1C make, then 23 make, then 23 break -> direction 0010, 0011, 0010; repeat follows 23 only, stops at its break, 1C gives no repeat.
REQ-033 game_over high in the same cycle as a 4D make -> status 0001, not pause; then 29 -> 1000.
REQ-034 E0 then clr for one cycle, then 75 -> status 0000, direction 0; 75 treated as plain make (no action).
REQ-035 In activate: press 1D, 4D make -> status 0010, direction 0000, no dir_step; 4D again -> 0100 with direction 1000 restored.
